// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and the decimal range helper.
package bin2bcd_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  localparam int unsigned BCD_W = 4;

  // 10**n, used to derive the largest value the digit field can display
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bin2bcd_seq_bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  // Conditional add-3; the result never exceeds 12 for legal digits
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with start/busy/done handshake and a result register held between conversions.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [BIN_W-1:0]        i_bin,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BCD_W*DIGITS-1:0] o_bcd,
  output logic                    o_overflow
);

  localparam int unsigned BCD_FW = BCD_W * DIGITS;
  localparam int unsigned SR_W   = BIN_W + BCD_FW;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
  localparam logic [31:0] MAXV   = 32'(pow10(DIGITS) - 32'd1);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [BCD_FW-1:0] bcd_q, bcd_d;
  logic              ovf_out_q, ovf_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [BCD_FW-1:0] bcd_adj_s;
  logic [SR_W-1:0]   sr_adj_s;
  logic [SR_W-1:0]   sr_shift_s;
  logic              last_shift_s;
  logic              in_ovf_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bin2bcd_seq_bcd_add3 u_add3 (
      .digit_i (sr_q[BIN_W + BCD_W*g +: BCD_W]),
      .digit_o (bcd_adj_s[BCD_W*g +: BCD_W])
    );
  end

  assign sr_adj_s     = {bcd_adj_s, sr_q[BIN_W-1:0]};
  assign sr_shift_s   = sr_adj_s << 1'b1;
  assign last_shift_s = (state_q == ST_CONV) && (cnt_q == CNT_W'(BIN_W - 1));
  assign in_ovf_s     = (32'(i_bin) > MAXV);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (last_shift_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CONV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    ovf_out_d = ovf_out_q;
    done_d    = 1'b0;
    busy_d    = (state_d == ST_CONV);
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          sr_d  = {{BCD_FW{1'b0}}, i_bin};
          cnt_d = '0;
          ovf_d = in_ovf_s;
        end else begin
          sr_d  = sr_q;
        end
      end
      ST_CONV: begin
        sr_d  = sr_shift_s;
        cnt_d = cnt_q + CNT_W'(1);
        // Results are published only here, so downstream never sees partial digits
        if (last_shift_s) begin
          done_d    = 1'b1;
          ovf_out_d = ovf_q;
          if (ovf_q) begin
            bcd_d = {DIGITS{4'h9}};
          end else begin
            bcd_d = sr_shift_s[SR_W-1 -: BCD_FW];
          end
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      ovf_out_q <= ovf_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_bcd      = bcd_q;
  assign o_overflow = ovf_out_q;

endmodule
